// File: rtl/minibyte_io_pkg.sv
// minibyte_io_pkg: register map, field positions and defaults shared by the I/O responder.
package minibyte_io_pkg;
  typedef enum logic [3:0] {
    OFF_RAM0   = 4'h0,
    OFF_RAM1   = 4'h1,
    OFF_RAM2   = 4'h2,
    OFF_RAM3   = 4'h3,
    OFF_RAM4   = 4'h4,
    OFF_RAM5   = 4'h5,
    OFF_RAM6   = 4'h6,
    OFF_RAM7   = 4'h7,
    OFF_GPO    = 4'h8,
    OFF_GPI    = 4'h9,
    OFF_TCTRL  = 4'hA,
    OFF_TCOUNT = 4'hB,
    OFF_TCMP   = 4'hC,
    OFF_STATUS = 4'hD,
    OFF_IRQEN  = 4'hE,
    OFF_ID     = 4'hF
  } reg_off_e;
  localparam int EN_BIT      = 0;
  localparam int AUTOCLR_BIT = 1;
  localparam int PS_LSB      = 2;
  localparam int PS_MSB      = 4;
  localparam int MATCH_BIT   = 0;
  localparam int GPICHG_BIT  = 1;
  localparam logic [7:0] ID_DEFAULT = 8'h4D;
endpackage

// File: rtl/minibyte_io_responder_if.sv
// minibyte_io_responder_if: CPU-side bus between the minibyte core and the I/O responder.
interface minibyte_io_responder_if;
  logic [7:0] addr_in;
  logic [7:0] data_in;
  logic       we_in;
  logic       drive_in;
  logic [7:0] data_out;
  logic       hit_out;
  modport slave (input addr_in, data_in, we_in, drive_in, output data_out, hit_out);
  modport master(output addr_in, data_in, we_in, drive_in, input data_out, hit_out);
endinterface

// File: rtl/minibyte_io_timer.sv
// minibyte_io_timer: prescaled 8-bit up-counter with compare, auto-clear and match strobe.
module minibyte_io_timer (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       en_i,
  input  logic       autoclr_i,
  input  logic [2:0] ps_i,
  input  logic [7:0] tcmp_i,
  input  logic       ctrl_wr_i,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  output logic [7:0] tcount_o,
  output logic       match_set_o
);
  logic [6:0] pre_q, pre_d, mask;
  logic [7:0] tcount_q, tcount_d;
  logic       tick;
  // a CPU load of TCOUNT pre-empts both the increment and the compare
  always_comb begin
    mask        = 7'((8'd1 << ps_i) - 8'd1);
    tick        = en_i && ((pre_q & mask) == mask);
    match_set_o = tick && !load_i && (tcount_q == tcmp_i);
    pre_d       = (ctrl_wr_i || !en_i) ? '0 : pre_q + 7'd1;
    tcount_d    = load_i ? load_data_i :
                  !tick ? tcount_q :
                  (match_set_o && autoclr_i) ? 8'h00 : tcount_q + 8'd1;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pre_q    <= '0;
      tcount_q <= '0;
    end else begin
      pre_q    <= pre_d;
      tcount_q <= tcount_d;
    end
  end
  assign tcount_o = tcount_q;
endmodule

// File: rtl/minibyte_io_responder.sv
// minibyte_io_responder: 16-byte memory-mapped I/O window with RAM, GPO, synchronised GPI,
// timer and sticky status/interrupt.
module minibyte_io_responder
  import minibyte_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'hF0,
  parameter logic [7:0] ID_VALUE    = ID_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  minibyte_io_responder_if.slave  bus,
  output logic [7:0]              gpo_out,
  input  logic [7:0]              gpi_in,
  output logic                    irq_out
);
  logic [7:0] ram_q [8];
  logic [7:0] gpo_q, tcmp_q, gpi_prev_q, rdata, tcount, gpi;
  logic [7:0] sync_q [SYNC_STAGES];
  logic [4:0] tctrl_q;
  logic [1:0] status_q, status_d, irqen_q, set_v, clr_v;
  logic [3:0] off;
  logic       hit, wr, irq_q, match_set;
  always_comb begin
    hit   = bus.addr_in[7:4] == BASE_ADDR[7:4];
    off   = bus.addr_in[3:0];
    wr    = hit && bus.we_in && bus.drive_in;
    gpi   = sync_q[SYNC_STAGES-1];
    set_v = '0;
    set_v[MATCH_BIT]  = match_set;
    set_v[GPICHG_BIT] = gpi != gpi_prev_q;
    clr_v    = (wr && off == OFF_STATUS) ? bus.data_in[1:0] : 2'b00;
    status_d = (status_q & ~clr_v) | set_v;
    case (off)
      OFF_GPO:    rdata = gpo_q;
      OFF_GPI:    rdata = gpi;
      OFF_TCTRL:  rdata = {3'b000, tctrl_q};
      OFF_TCOUNT: rdata = tcount;
      OFF_TCMP:   rdata = tcmp_q;
      OFF_STATUS: rdata = {6'b0, status_q};
      OFF_IRQEN:  rdata = {6'b0, irqen_q};
      OFF_ID:     rdata = ID_VALUE;
      default:    rdata = ram_q[off[2:0]];
    endcase
  end
  minibyte_io_timer u_timer (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en_i       (tctrl_q[EN_BIT]),
    .autoclr_i  (tctrl_q[AUTOCLR_BIT]),
    .ps_i       (tctrl_q[PS_MSB:PS_LSB]),
    .tcmp_i     (tcmp_q),
    .ctrl_wr_i  (wr && off == OFF_TCTRL),
    .load_i     (wr && off == OFF_TCOUNT),
    .load_data_i(bus.data_in),
    .tcount_o   (tcount),
    .match_set_o(match_set)
  );
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 8; i++) ram_q[i] <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      gpo_q      <= '0;
      tcmp_q     <= '0;
      tctrl_q    <= '0;
      irqen_q    <= '0;
      status_q   <= '0;
      gpi_prev_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr) begin
        case (off)
          OFF_GPO:   gpo_q   <= bus.data_in;
          OFF_TCTRL: tctrl_q <= bus.data_in[PS_MSB:0];
          OFF_TCMP:  tcmp_q  <= bus.data_in;
          OFF_IRQEN: irqen_q <= bus.data_in[1:0];
          default:   if (!off[3]) ram_q[off[2:0]] <= bus.data_in;
        endcase
      end
      sync_q[0] <= gpi_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      gpi_prev_q <= gpi;
      status_q   <= status_d;
      // irq follows the registered flags, so it lags a flag set by one cycle
      irq_q      <= |(status_q & irqen_q);
    end
  end
  assign bus.hit_out  = hit;
  assign bus.data_out = (hit && !bus.drive_in) ? rdata : 8'h00;
  assign gpo_out      = gpo_q;
  assign irq_out      = irq_q;
endmodule
